// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-port round-robin arbiter for the single memory/IO port.
//                Each granted access runs through an address phase, a fixed
//                wait of MEM_LAT cycles and a one-cycle acknowledge.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2      // legal range 1..15 (wait counter is 4 bits)
) (
    input  logic          clk,
    input  logic          rst,       // asynchronous, active-low
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    // Counter reload so that WAIT spans exactly MEM_LAT cycles
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state_q;
    state_t     state_d;
    logic       we_r;
    logic       last;        // port that completed most recently
    logic [3:0] cnt;
    logic       any_req;
    logic       grant_port;

    // Arbitration: single requester wins outright, a tie goes to the port not served last
    always_comb begin
        any_req    = req0 | req1;
        grant_port = (req0 && req1) ? ~last : req1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADDR;
            ADDR:    state_d = WAIT;
            WAIT:    if (cnt == 4'd0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the granted request, run the wait counter, capture read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_r      <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= 4'd0;
            rdata     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner <= grant_port;
                        if (grant_port) begin
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                            we_r      <= we1;
                        end else begin
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                            we_r      <= we0;
                        end
                    end
                end
                ADDR: cnt <= LAT_M1;
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Captured for writes too, so rdata reflects the addressed word
                        rdata <= mem_rdata;
                    end
                end
                ACK:     last <= owner;
                default: ;
            endcase
        end
    end

    // Decoded outputs; all derive from registered state so they clear with reset at once
    assign busy      = (state_q != IDLE);
    assign mem_write = (state_q == ADDR) && we_r;
    assign ack0      = (state_q == ACK) && !owner;
    assign ack1      = (state_q == ACK) && owner;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter. Three instances with
//                MEM_LAT = 2, 1 and 15 share one clock, reset and memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       mem_init;
    logic       req0 [3];
    logic       we0 [3];
    logic       req1 [3];
    logic       we1 [3];
    logic       ack0 [3];
    logic       ack1 [3];
    logic       mem_write [3];
    logic       owner [3];
    logic       busy [3];
    logic [1:0] state [3];
    logic [7:0] addr0 [3];
    logic [7:0] wdata0 [3];
    logic [7:0] addr1 [3];
    logic [7:0] wdata1 [3];
    logic [7:0] rdata [3];
    logic [7:0] mem_addr [3];
    logic [7:0] mem_wdata [3];
    logic [7:0] mem_rdata [3];
    logic [7:0] mem [256];

    int n_tests;
    int n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_bus_arbiter #(
            .AW(8), .DW(8), .MEM_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk(clk), .rst(rst),
            .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]), .ack0(ack0[g]),
            .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]), .ack1(ack1[g]),
            .rdata(rdata[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g]),
            .owner(owner[g]), .busy(busy[g]), .state(state[g])
        );
        assign mem_rdata[g] = mem[mem_addr[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preload pattern mem[a] = a ^ 5A, except mem[10] = A5
    always @(posedge clk) begin
        if (mem_init) begin
            for (int j = 0; j < 256; j++) mem[j] <= 8'(j) ^ 8'h5A;
            mem[8'h10] <= 8'hA5;
        end else begin
            for (int k = 0; k < 3; k++)
                if (mem_write[k]) mem[mem_addr[k]] <= mem_wdata[k];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One access on instance i from IDLE; reports timing and observed values
    task automatic txn(input int i, input bit port, input bit we,
                       input logic [7:0] a, input logic [7:0] d,
                       output int lat_seen, output int wr_cnt, output int wait_cnt,
                       output logic [7:0] ma, output logic [7:0] mw,
                       output logic [7:0] rd, output int stray);
        lat_seen = -1; wr_cnt = 0; wait_cnt = 0; stray = 0;
        ma = '0; mw = '0; rd = '0;
        if (!port) begin we0[i] = we; addr0[i] = a; wdata0[i] = d; req0[i] = 1'b1; end
        else       begin we1[i] = we; addr1[i] = a; wdata1[i] = d; req1[i] = 1'b1; end
        @(posedge clk); #1;                       // grant edge has passed
        // Scramble the request fields: the latched copies must not follow
        if (!port) begin addr0[i] = ~a; wdata0[i] = ~d; we0[i] = ~we; end
        else       begin addr1[i] = ~a; wdata1[i] = ~d; we1[i] = ~we; end
        for (int k = 1; k <= 40; k++) begin
            if (mem_write[i]) wr_cnt++;
            if (state[i] == 2'd2) wait_cnt++;
            if (port ? ack0[i] : ack1[i]) stray++;
            if (port ? ack1[i] : ack0[i]) begin
                lat_seen = k; rd = rdata[i]; ma = mem_addr[i]; mw = mem_wdata[i];
                break;
            end
            @(posedge clk); #1;
        end
        req0[i] = 1'b0; req1[i] = 1'b0;
        @(posedge clk); #1;
        if (mem_write[i] || ack0[i] || ack1[i] || busy[i]) stray++;
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat_seen, wr_cnt, wait_cnt, stray, nack, both, acks, wrs;
        int order [4];
        bit raise0, raise1;
        logic [7:0] ma, mw, rd;

        n_tests = 0; n_fail = 0;
        // port, we, addr, wdata, expected rdata at ack
        vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h3C};
        vecs[2] = '{1'b0, 1'b1, 8'h20, 8'hC3, 8'hC3};
        vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h11, 8'hC3};
        vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'h22, 8'hA5};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h33, 8'h5A};

        for (int i = 0; i < 3; i++) begin
            req0[i] = 0; we0[i] = 0; addr0[i] = 0; wdata0[i] = 0;
            req1[i] = 0; we1[i] = 0; addr1[i] = 0; wdata1[i] = 0;
        end
        rst = 1'b0; mem_init = 1'b1;

        // T1: reset held with random activity on instance 0
        repeat (4) begin
            @(posedge clk); #1;
            req0[0] = 1'($urandom); we0[0] = 1'($urandom);
            addr0[0] = 8'($urandom); wdata0[0] = 8'($urandom);
            req1[0] = 1'($urandom); we1[0] = 1'($urandom);
            addr1[0] = 8'($urandom); wdata1[0] = 8'($urandom);
        end
        #1;
        chk("rst_ack0", 32'(ack0[0]), 0);
        chk("rst_ack1", 32'(ack1[0]), 0);
        chk("rst_mem_write", 32'(mem_write[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_owner", 32'(owner[0]), 0);
        chk("rst_state", 32'(state[0]), 0);
        chk("rst_mem_addr", 32'(mem_addr[0]), 0);
        chk("rst_mem_wdata", 32'(mem_wdata[0]), 0);
        chk("rst_rdata", 32'(rdata[0]), 0);
        chk("rst_state_lat1", 32'(state[1]), 0);
        chk("rst_state_lat15", 32'(state[2]), 0);
        req0[0] = 0; req1[0] = 0; we0[0] = 0; we1[0] = 0;
        @(posedge clk); #1;
        mem_init = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_state", 32'(state[0]), 0);
        chk("idle_busy", 32'(busy[0]), 0);

        // T2/T3 and variants: table of single accesses on the MEM_LAT=2 instance
        for (int v = 0; v < 6; v++) begin
            txn(0, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                lat_seen, wr_cnt, wait_cnt, ma, mw, rd, stray);
            chk($sformatf("v%0d_latency", v), 32'(lat_seen), 4);
            chk($sformatf("v%0d_writes", v), 32'(wr_cnt), 32'(vecs[v].we));
            chk($sformatf("v%0d_wait", v), 32'(wait_cnt), 2);
            chk($sformatf("v%0d_mem_addr", v), 32'(ma), 32'(vecs[v].addr));
            chk($sformatf("v%0d_mem_wdata", v), 32'(mw), 32'(vecs[v].wdata));
            chk($sformatf("v%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rd));
            chk($sformatf("v%0d_stray", v), 32'(stray), 0);
        end

        // T4: both ports requesting from reset release, expect 0,1,0,1
        @(posedge clk); #1;
        rst = 1'b0;
        addr0[0] = 8'h10; addr1[0] = 8'h00; we0[0] = 0; we1[0] = 0;
        req0[0] = 1; req1[0] = 1;
        @(posedge clk); #1;
        rst = 1'b1;
        nack = 0; both = 0; raise0 = 0; raise1 = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (raise0) begin req0[0] = 1; raise0 = 0; end
            if (raise1) begin req1[0] = 1; raise1 = 0; end
            if (ack0[0] && ack1[0]) both++;
            if (ack0[0] && nack < 4) begin order[nack] = 0; nack++; req0[0] = 0; raise0 = 1; end
            else if (ack1[0] && nack < 4) begin order[nack] = 1; nack++; req1[0] = 0; raise1 = 1; end
            if (nack == 4) break;
        end
        req0[0] = 0; req1[0] = 0;
        chk("tie_ack_count", 32'(nack), 4);
        for (int n = 0; n < 4; n++)
            if (n < nack) chk($sformatf("tie_order%0d", n), 32'(order[n]), 32'(n % 2));
        chk("tie_both_acks", 32'(both), 0);
        repeat (2) @(posedge clk);
        #1;

        // T5: reset during WAIT of a port 0 write, then rerun after release
        we0[0] = 1; addr0[0] = 8'h30; wdata0[0] = 8'h77; req0[0] = 1;
        @(posedge clk); #1;
        chk("abort_in_addr", 32'(state[0]), 1);
        @(posedge clk); #1;
        chk("abort_in_wait", 32'(state[0]), 2);
        #2 rst = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write[0]), 0);
        chk("abort_ack0", 32'(ack0[0]), 0);
        chk("abort_state", 32'(state[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        acks = 0; wrs = 0; rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (mem_write[0]) wrs++;
            if (ack0[0]) begin acks++; rd = rdata[0]; req0[0] = 0; end
        end
        chk("rerun_ack0_pulses", 32'(acks), 1);
        chk("rerun_writes", 32'(wrs), 1);
        chk("rerun_rdata", 32'(rd), 32'h77);

        // T6: MEM_LAT = 1 and 15 instances
        for (int i = 1; i < 3; i++) begin
            int lat;
            lat = (i == 1) ? 1 : 15;
            txn(i, 1'b0, 1'b0, 8'h10, 8'h00, lat_seen, wr_cnt, wait_cnt, ma, mw, rd, stray);
            chk($sformatf("lat%0d_rd_latency", lat), 32'(lat_seen), 32'(lat + 2));
            chk($sformatf("lat%0d_rd_wait", lat), 32'(wait_cnt), 32'(lat));
            chk($sformatf("lat%0d_rd_rdata", lat), 32'(rd), 32'hA5);
            chk($sformatf("lat%0d_rd_writes", lat), 32'(wr_cnt), 0);
            chk($sformatf("lat%0d_rd_stray", lat), 32'(stray), 0);
            txn(i, 1'b1, 1'b1, 8'h40, 8'h96, lat_seen, wr_cnt, wait_cnt, ma, mw, rd, stray);
            chk($sformatf("lat%0d_wr_latency", lat), 32'(lat_seen), 32'(lat + 2));
            chk($sformatf("lat%0d_wr_wait", lat), 32'(wait_cnt), 32'(lat));
            chk($sformatf("lat%0d_wr_writes", lat), 32'(wr_cnt), 1);
            chk($sformatf("lat%0d_wr_mem_addr", lat), 32'(ma), 32'h40);
            chk($sformatf("lat%0d_wr_rdata", lat), 32'(rd), 32'h96);
            chk($sformatf("lat%0d_wr_stray", lat), 32'(stray), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
